// File: rtl/control_unit.sv
// Multi-cycle control FSM for datapath_with_uc: FETCH -> DECODE -> EXEC [-> MEM]
// for RV64I opcode classes, with sticky illegal/bus-error halts and an
// instruction-retired counter.
module control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic [1:0]           RF_din_sel,
  output logic                 ULA_din2_sel,
  output logic                 load_pc,
  output logic                 load_ir,
  output logic                 pc_next_sel,
  output logic                 pc_adder_sel,
  output logic                 mem_addr_sel,
  output logic                 mem_req,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [2:0]           state
);

  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;

  // Wait counter only needs to reach TIMEOUT_CYCLES-1 before the error fires.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_error_q, bus_error_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 timeout_hit;
  logic                 opc_legal;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST);

  // Classify the opcode as one of the supported RV64I classes.
  always_comb begin
    opc_legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: opc_legal = 1'b1;
      default: opc_legal = 1'b0;
    endcase
  end

  // Next-state, sticky-flag and control-output decode from state and opcode.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_error_d  = bus_error_q;
    wait_d       = '0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    mem_addr_sel = 1'b0;
    mem_req      = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (opc_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        load_pc = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OPC_OP, OPC_OP32: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b01;
          end
          OPC_OPIMM, OPC_OPIMM32, OPC_LUI: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b01;
            ULA_din2_sel = 1'b1;
          end
          OPC_AUIPC: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b11;
          end
          OPC_JAL: begin
            WE_RF       = 1'b1;
            RF_din_sel  = 2'b10;
            pc_next_sel = 1'b1;
          end
          OPC_JALR: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b10;
            ULA_din2_sel = 1'b1;
            pc_adder_sel = 1'b1;
            pc_next_sel  = 1'b1;
          end
          OPC_BRANCH: pc_next_sel = 1'b1;
          OPC_LOAD, OPC_STORE: begin
            load_pc      = 1'b0;
            ULA_din2_sel = 1'b1;
            state_d      = S_MEM;
          end
          default: begin
            // IR changed under us: treat as illegal rather than retire garbage.
            load_pc   = 1'b0;
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        ULA_din2_sel = 1'b1;
        WE_MEM       = (opcode == OPC_STORE);
        if (mem_ready) begin
          WE_RF   = (opcode == OPC_LOAD);
          load_pc = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    instret_d = instret_q + CNT_WIDTH'(load_pc);
  end

  // State, sticky flags, wait counter and retire counter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_START;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      instret_q   <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      instret_q   <= instret_d;
      wait_q      <= wait_d;
    end
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign instret   = instret_q;
  assign state     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each stimulus cycle pushes its expected
// state/controls/flags/count; a monitor pops and compares on the falling edge.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        WE_RF, WE_MEM, ULA_din2_sel, load_pc, load_ir;
  logic        pc_next_sel, pc_adder_sel, mem_addr_sel, mem_req;
  logic        illegal, bus_error;
  logic [1:0]  RF_din_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  always #5 CLK = ~CLK;

  control_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
    .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .load_ir(load_ir),
    .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
    .mem_addr_sel(mem_addr_sel), .mem_req(mem_req), .illegal(illegal),
    .bus_error(bus_error), .instret(instret), .state(state)
  );

  // Control vector: {WE_RF, WE_MEM, RF_din_sel[1:0], ULA_din2_sel, load_pc,
  //                  load_ir, pc_next_sel, pc_adder_sel, mem_addr_sel, mem_req}
  localparam logic [10:0] WERF  = 11'b100_0000_0000;
  localparam logic [10:0] WEMEM = 11'b010_0000_0000;
  localparam logic [10:0] RF01  = 11'b000_1000_0000;
  localparam logic [10:0] RF10  = 11'b001_0000_0000;
  localparam logic [10:0] RF11  = 11'b001_1000_0000;
  localparam logic [10:0] ULA2  = 11'b000_0100_0000;
  localparam logic [10:0] LPC   = 11'b000_0010_0000;
  localparam logic [10:0] LIR   = 11'b000_0001_0000;
  localparam logic [10:0] PCN   = 11'b000_0000_1000;
  localparam logic [10:0] PCA   = 11'b000_0000_0100;
  localparam logic [10:0] MAS   = 11'b000_0000_0010;
  localparam logic [10:0] MRQ   = 11'b000_0000_0001;

  localparam logic [10:0] C_NONE      = 11'd0;
  localparam logic [10:0] C_FETCH     = MRQ;
  localparam logic [10:0] C_FETCH_RDY = MRQ | LIR;
  localparam logic [10:0] C_OP        = WERF | RF01 | LPC;
  localparam logic [10:0] C_OPI       = WERF | RF01 | ULA2 | LPC;
  localparam logic [10:0] C_AUIPC     = WERF | RF11 | LPC;
  localparam logic [10:0] C_JAL       = WERF | RF10 | PCN | LPC;
  localparam logic [10:0] C_JALR      = WERF | RF10 | ULA2 | PCA | PCN | LPC;
  localparam logic [10:0] C_BR        = PCN | LPC;
  localparam logic [10:0] C_LS_EXEC   = ULA2;
  localparam logic [10:0] C_LD_WAIT   = MRQ | MAS | ULA2;
  localparam logic [10:0] C_LD_DONE   = MRQ | MAS | ULA2 | WERF | LPC;
  localparam logic [10:0] C_ST_WAIT   = MRQ | MAS | ULA2 | WEMEM;
  localparam logic [10:0] C_ST_DONE   = MRQ | MAS | ULA2 | WEMEM | LPC;

  localparam logic [2:0] S_START = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3, S_MEM = 3'd4, S_HALT = 3'd7;

  localparam logic [6:0] O_OP = 7'b0110011, O_OP32 = 7'b0111011;
  localparam logic [6:0] O_OPI = 7'b0010011, O_OPI32 = 7'b0011011;
  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111, O_JALR = 7'b1100111;
  localparam logic [6:0] O_BR = 7'b1100011, O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011, O_BAD = 7'b1111111;

  typedef struct {
    logic [2:0]  st;
    logic [10:0] ctrl;
    logic        ill;
    logic        be;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s entry=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic step(input logic rst, input logic [6:0] opc, input logic rdy,
                      input logic [2:0] st, input logic [10:0] ctrl,
                      input logic ill, input logic be, input logic [31:0] ret);
    exp_t e;
    @(posedge CLK);
    #1;
    reset     = rst;
    opcode    = opc;
    mem_ready = rdy;
    e.st = st; e.ctrl = ctrl; e.ill = ill; e.be = be; e.ret = ret;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    step(1'b1, 7'd0, 1'b0, S_START, C_NONE, 1'b0, 1'b0, 32'd0);
    step(1'b0, 7'd0, 1'b0, S_START, C_NONE, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic fetch_decode(input logic [6:0] opc, input logic [31:0] ret);
    step(1'b0, opc, 1'b1, S_FETCH,  C_FETCH_RDY, 1'b0, 1'b0, ret);
    step(1'b0, opc, 1'b1, S_DECODE, C_NONE,      1'b0, 1'b0, ret);
  endtask

  task automatic alu_instr(input logic [6:0] opc, input logic [10:0] ctrl,
                           input logic [31:0] ret);
    fetch_decode(opc, ret);
    step(1'b0, opc, 1'b1, S_EXEC, ctrl, 1'b0, 1'b0, ret);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("state", idx, {29'd0, state}, {29'd0, e.st});
        chk("ctrl", idx, {21'd0, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
                          load_ir, pc_next_sel, pc_adder_sel, mem_addr_sel, mem_req},
            {21'd0, e.ctrl});
        chk("flags", idx, {30'd0, illegal, bus_error}, {30'd0, e.ill, e.be});
        chk("instret", idx, instret, e.ret);
        idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // ADDI: F, D, E with retire
    alu_instr(O_OPI, C_OPI, 32'd0);

    // LOAD with three MEM wait cycles, then ready
    fetch_decode(O_LD, 32'd1);
    step(1'b0, O_LD, 1'b1, S_EXEC, C_LS_EXEC, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++)
      step(1'b0, O_LD, 1'b0, S_MEM, C_LD_WAIT, 1'b0, 1'b0, 32'd1);
    step(1'b0, O_LD, 1'b1, S_MEM, C_LD_DONE, 1'b0, 1'b0, 32'd1);

    // STORE, ready immediately
    fetch_decode(O_ST, 32'd2);
    step(1'b0, O_ST, 1'b1, S_EXEC, C_LS_EXEC, 1'b0, 1'b0, 32'd2);
    step(1'b0, O_ST, 1'b1, S_MEM, C_ST_DONE, 1'b0, 1'b0, 32'd2);

    // Remaining single-EXEC classes
    alu_instr(O_JALR,  C_JALR,  32'd3);
    alu_instr(O_OP,    C_OP,    32'd4);
    alu_instr(O_OP32,  C_OP,    32'd5);
    alu_instr(O_LUI,   C_OPI,   32'd6);
    alu_instr(O_AUIPC, C_AUIPC, 32'd7);
    alu_instr(O_JAL,   C_JAL,   32'd8);
    alu_instr(O_BR,    C_BR,    32'd9);
    alu_instr(O_OPI32, C_OPI,   32'd10);

    // Reset asserted while a STORE is waiting in MEM
    fetch_decode(O_ST, 32'd11);
    step(1'b0, O_ST, 1'b1, S_EXEC, C_LS_EXEC, 1'b0, 1'b0, 32'd11);
    step(1'b0, O_ST, 1'b0, S_MEM, C_ST_WAIT, 1'b0, 1'b0, 32'd11);
    step(1'b1, O_ST, 1'b0, S_START, C_NONE, 1'b0, 1'b0, 32'd0);
    step(1'b0, O_ST, 1'b0, S_START, C_NONE, 1'b0, 1'b0, 32'd0);
    alu_instr(O_OPI, C_OPI, 32'd0);

    // FETCH timeout: four waits, then HALT with bus_error; HALT ignores ready
    for (int i = 0; i < 4; i++)
      step(1'b0, O_OPI, 1'b0, S_FETCH, C_FETCH, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++)
      step(1'b0, O_OPI, 1'b1, S_HALT, C_NONE, 1'b0, 1'b1, 32'd1);
    do_reset();

    // Ready on the fourth wait cycle wins over the timeout
    for (int i = 0; i < 3; i++)
      step(1'b0, O_OPI, 1'b0, S_FETCH, C_FETCH, 1'b0, 1'b0, 32'd0);
    step(1'b0, O_OPI, 1'b1, S_FETCH, C_FETCH_RDY, 1'b0, 1'b0, 32'd0);
    step(1'b0, O_OPI, 1'b1, S_DECODE, C_NONE, 1'b0, 1'b0, 32'd0);
    step(1'b0, O_OPI, 1'b1, S_EXEC, C_OPI, 1'b0, 1'b0, 32'd0);

    // MEM timeout on a LOAD
    fetch_decode(O_LD, 32'd1);
    step(1'b0, O_LD, 1'b1, S_EXEC, C_LS_EXEC, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 4; i++)
      step(1'b0, O_LD, 1'b0, S_MEM, C_LD_WAIT, 1'b0, 1'b0, 32'd1);
    step(1'b0, O_LD, 1'b1, S_HALT, C_NONE, 1'b0, 1'b1, 32'd1);
    do_reset();

    // Illegal opcode: DECODE -> HALT, sticky for 20 cycles, cleared by reset
    step(1'b0, O_BAD, 1'b1, S_FETCH, C_FETCH_RDY, 1'b0, 1'b0, 32'd0);
    step(1'b0, O_BAD, 1'b1, S_DECODE, C_NONE, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++)
      step(1'b0, O_BAD, i[0], S_HALT, C_NONE, 1'b1, 1'b0, 32'd0);
    do_reset();
    step(1'b0, O_OPI, 1'b1, S_FETCH, C_FETCH_RDY, 1'b0, 1'b0, 32'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
